// File: rtl/matrix_loader.sv
// Serial-to-parallel operand loader feeding matrix_mult_matrix: streams elements into two
// flattened matrix buses, pulses o_calc, holds for CALC_HOLD cycles, then pulses o_done.
// Optional build macro MATRIX_LOADER_COLMAJOR_EN: matrix 2 elements arrive column-major.
module matrix_loader #(
    parameter int FIRST_MATRIX_HEIGHT = 5,
    parameter int BOTH_MATRIX_W_H     = 5,
    parameter int SECOND_MATRIX_WIDTH = 5,
    parameter int DATA_WIDTH          = 8,
    parameter int CALC_HOLD           = 3
) (
    input  logic                                                      clk,
    input  logic                                                      i_rst,
    input  logic                                                      i_valid,
    input  logic [DATA_WIDTH-1:0]                                     i_data,
    input  logic                                                      i_flush,
    output logic                                                      o_ready,
    output logic [FIRST_MATRIX_HEIGHT*BOTH_MATRIX_W_H*DATA_WIDTH-1:0] o_matrix_1,
    output logic [BOTH_MATRIX_W_H*SECOND_MATRIX_WIDTH*DATA_WIDTH-1:0] o_matrix_2,
    output logic                                                      o_calc,
    output logic                                                      o_done
);

    localparam int N1     = FIRST_MATRIX_HEIGHT * BOTH_MATRIX_W_H;
    localparam int N2     = BOTH_MATRIX_W_H * SECOND_MATRIX_WIDTH;
    localparam int NT     = N1 + N2;
    localparam int IDX_W  = (NT > 1) ? $clog2(NT) : 1;
    localparam int HOLD_W = (CALC_HOLD > 1) ? $clog2(CALC_HOLD) : 1;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FIRE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [IDX_W-1:0]       idx_r;
    logic [HOLD_W-1:0]      hold_cnt_r;
    logic [N1*DATA_WIDTH-1:0] m1_r;
    logic [N2*DATA_WIDTH-1:0] m2_r;
    logic                   calc_r;
    logic                   done_r;
    logic                   ready_s;
    logic                   accept_s;
    logic                   last_s;
    logic                   calc_next_s;
    logic                   done_next_s;

    // Bus slot for the s-th matrix-2 element of the stream.
    function automatic int m2_dest(input int s);
`ifdef MATRIX_LOADER_COLMAJOR_EN
        return (s % BOTH_MATRIX_W_H) * SECOND_MATRIX_WIDTH + (s / BOTH_MATRIX_W_H);
`else
        return s;
`endif
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (accept_s && last_s) begin
                    state_next_s = ST_FIRE;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_FIRE: state_next_s = ST_HOLD;
            ST_HOLD: begin
                if (hold_cnt_r == {HOLD_W{1'b0}}) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: state_next_s = ST_LOAD;
        endcase
    end

    // Output decode; o_done is launched one cycle early so the registered pulse lands on the last hold cycle.
    always_comb begin
        ready_s     = (state_r == ST_LOAD) && !i_rst;
        accept_s    = ready_s && i_valid && !i_flush;
        last_s      = (idx_r == IDX_W'(NT - 1));
        calc_next_s = (state_next_s == ST_FIRE);
        done_next_s = 1'b0;
        case (state_r)
            ST_FIRE: done_next_s = (CALC_HOLD == 1);
            ST_HOLD: done_next_s = (hold_cnt_r == HOLD_W'(1));
            default: done_next_s = 1'b0;
        endcase
    end

    // Registered strobes.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            calc_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            calc_r <= calc_next_s;
            done_r <= done_next_s;
        end
    end

    // Element index and hold countdown.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            idx_r      <= {IDX_W{1'b0}};
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else begin
            if (state_r == ST_LOAD && i_flush) begin
                idx_r <= {IDX_W{1'b0}};
            end else if (accept_s) begin
                idx_r <= last_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
            end else begin
                idx_r <= idx_r;
            end
            if (state_r == ST_FIRE) begin
                hold_cnt_r <= HOLD_W'(CALC_HOLD - 1);
            end else if (state_r == ST_HOLD && hold_cnt_r != {HOLD_W{1'b0}}) begin
                hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
        end
    end

    // Operand storage: only accepted elements write; contents persist across loads.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            m1_r <= {(N1*DATA_WIDTH){1'b0}};
            m2_r <= {(N2*DATA_WIDTH){1'b0}};
        end else if (accept_s) begin
            for (int i = 0; i < N1; i++) begin
                if (idx_r == IDX_W'(i)) begin
                    m1_r[i*DATA_WIDTH +: DATA_WIDTH] <= i_data;
                end
            end
            for (int s = 0; s < N2; s++) begin
                if (idx_r == IDX_W'(N1 + s)) begin
                    m2_r[m2_dest(s)*DATA_WIDTH +: DATA_WIDTH] <= i_data;
                end
            end
        end else begin
            m1_r <= m1_r;
            m2_r <= m2_r;
        end
    end

    assign o_ready    = ready_s;
    assign o_matrix_1 = m1_r;
    assign o_matrix_2 = m2_r;
    assign o_calc     = calc_r;
    assign o_done     = done_r;

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader (2x2 by 2x2, 8-bit, hold 3) against an element-level model.
module tb_matrix_loader;

    localparam int H  = 2;
    localparam int BW = 2;
    localparam int SW = 2;
    localparam int DW = 8;
    localparam int CH = 3;
    localparam int N1 = H * BW;
    localparam int N2 = BW * SW;

    logic                 clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_valid = 1'b0;
    logic [DW-1:0]        i_data = 8'h00;
    logic                 i_flush = 1'b0;
    logic                 o_ready;
    logic [N1*DW-1:0]     o_matrix_1;
    logic [N2*DW-1:0]     o_matrix_2;
    logic                 o_calc;
    logic                 o_done;

    int total = 0;
    int bad   = 0;

    // Reference model: matrices indexed by (row, col), stream position, cycles left before reopening.
    int mdl_m1[H][BW];
    int mdl_m2[BW][SW];
    int mdl_idx  = 0;
    int mdl_busy = 0;

`ifdef MATRIX_LOADER_COLMAJOR_EN
    localparam logic [31:0] SEQ_M2 = 32'h08060705;
`else
    localparam logic [31:0] SEQ_M2 = 32'h08070605;
`endif

    matrix_loader #(
        .FIRST_MATRIX_HEIGHT(H),
        .BOTH_MATRIX_W_H    (BW),
        .SECOND_MATRIX_WIDTH(SW),
        .DATA_WIDTH         (DW),
        .CALC_HOLD          (CH)
    ) dut (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .i_flush   (i_flush),
        .o_ready   (o_ready),
        .o_matrix_1(o_matrix_1),
        .o_matrix_2(o_matrix_2),
        .o_calc    (o_calc),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    function automatic logic [N1*DW-1:0] exp_m1();
        logic [N1*DW-1:0] v = '0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < BW; c++)
                v[(r*BW+c)*DW +: DW] = mdl_m1[r][c][DW-1:0];
        return v;
    endfunction

    function automatic logic [N2*DW-1:0] exp_m2();
        logic [N2*DW-1:0] v = '0;
        for (int k = 0; k < BW; k++)
            for (int j = 0; j < SW; j++)
                v[(k*SW+j)*DW +: DW] = mdl_m2[k][j][DW-1:0];
        return v;
    endfunction

    task automatic mdl_clear();
        for (int r = 0; r < H; r++) for (int c = 0; c < BW; c++) mdl_m1[r][c] = 0;
        for (int k = 0; k < BW; k++) for (int j = 0; j < SW; j++) mdl_m2[k][j] = 0;
        mdl_idx  = 0;
        mdl_busy = 0;
    endtask

    task automatic mdl_store(input int d);
        int s;
        if (mdl_idx < N1) begin
            mdl_m1[mdl_idx / BW][mdl_idx % BW] = d;
        end else begin
            s = mdl_idx - N1;
`ifdef MATRIX_LOADER_COLMAJOR_EN
            mdl_m2[s % BW][s / BW] = d;
`else
            mdl_m2[s / SW][s % SW] = d;
`endif
        end
    endtask

    // One clock: drive, check at the falling edge, advance the model at the rising edge.
    task automatic cycle(input logic rst, input logic v, input logic [DW-1:0] d, input logic f);
        logic er, ec, ed;
        logic [N1*DW-1:0] e1;
        logic [N2*DW-1:0] e2;
        i_rst = rst; i_valid = v; i_data = d; i_flush = f;
        er = !rst && (mdl_busy == 0);
        ec = (mdl_busy == CH + 1);
        ed = (mdl_busy == 1);
        e1 = exp_m1();
        e2 = exp_m2();
        @(negedge clk);
        total++;
        assert (o_ready === er) else begin bad++; $error("FAIL ready got=%0b exp=%0b", o_ready, er); end
        total++;
        assert (o_calc === ec) else begin bad++; $error("FAIL calc got=%0b exp=%0b", o_calc, ec); end
        total++;
        assert (o_done === ed) else begin bad++; $error("FAIL done got=%0b exp=%0b", o_done, ed); end
        total++;
        assert (o_matrix_1 === e1) else begin bad++; $error("FAIL m1 got=%h exp=%h", o_matrix_1, e1); end
        total++;
        assert (o_matrix_2 === e2) else begin bad++; $error("FAIL m2 got=%h exp=%h", o_matrix_2, e2); end
        @(posedge clk);
        if (rst) begin
            mdl_clear();
        end else if (mdl_busy > 0) begin
            mdl_busy--;
        end else if (f) begin
            mdl_idx = 0;
        end else if (v) begin
            mdl_store(int'(d));
            if (mdl_idx == N1 + N2 - 1) begin
                mdl_idx  = 0;
                mdl_busy = CH + 1;
            end else begin
                mdl_idx++;
            end
        end
        #1;
    endtask

    initial begin
        mdl_clear();
        @(posedge clk);
        #1;
        // Reset held, then released.
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);

        // Back-to-back stream 1..8.
        for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
        total++;
        assert (o_matrix_1 === 32'h04030201) else begin bad++; $error("FAIL seq_m1 got=%h exp=%h", o_matrix_1, 32'h04030201); end
        total++;
        assert (o_matrix_2 === SEQ_M2) else begin bad++; $error("FAIL seq_m2 got=%h exp=%h", o_matrix_2, SEQ_M2); end

        // Valid held with 0xFF through FIRE/HOLD (flush ignored there), then the first accept lands at 0.
        for (int i = 0; i < CH + 1; i++) cycle(1'b0, 1'b1, 8'hFF, i[0]);
        cycle(1'b0, 1'b1, 8'hFF, 1'b0);
        total++;
        assert (o_matrix_1[7:0] === 8'hFF) else begin bad++; $error("FAIL idx0 got=%h exp=%h", o_matrix_1[7:0], 8'hFF); end

        // Flush scenario.
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
        cycle(1'b0, 1'b1, 8'hAA, 1'b1);
        for (int i = 10; i <= 17; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
        total++;
        assert (o_matrix_1 === 32'h0D0C0B0A) else begin bad++; $error("FAIL flush_m1 got=%h exp=%h", o_matrix_1, 32'h0D0C0B0A); end
`ifdef MATRIX_LOADER_COLMAJOR_EN
        total++;
        assert (o_matrix_2 === 32'h110F100E) else begin bad++; $error("FAIL flush_m2 got=%h exp=%h", o_matrix_2, 32'h110F100E); end
`else
        total++;
        assert (o_matrix_2 === 32'h11100F0E) else begin bad++; $error("FAIL flush_m2 got=%h exp=%h", o_matrix_2, 32'h11100F0E); end
`endif
        for (int i = 0; i < CH + 1; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset in the hold cycle before o_done.
        for (int i = 0; i < N1 + N2; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
        while (mdl_busy > 2) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h5A, 1'b0);
        total++;
        assert (o_matrix_1 === 32'h0000005A) else begin bad++; $error("FAIL rst_idx0 got=%h exp=%h", o_matrix_1, 32'h0000005A); end

        // Randomized traffic with gaps and occasional flushes.
        for (int i = 0; i < 400; i++)
            cycle(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 15) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Upstream feeder for `matrix_mult_matrix`. Accepts a serial stream of matrix elements over a valid/ready handshake and assembles them into the flattened `o_matrix_1` / `o_matrix_2` buses. When both operands are complete it issues a one-cycle `o_calc` start pulse, holds the operands stable for a fixed compute window, then signals `o_done` and reopens for the next pair.

## Interface
- `FIRST_MATRIX_HEIGHT`, 5: rows of matrix 1.
- `BOTH_MATRIX_W_H`, 5: columns of matrix 1, which equal the rows of matrix 2.
- `SECOND_MATRIX_WIDTH`, 5: columns of matrix 2.
- `DATA_WIDTH`, 8: element width in bits.
- `CALC_HOLD`, 3: number of cycles the operands are held after `o_calc` (≥1).
- `clk` in 1: single clock; all logic on posedge.
- `i_rst` in 1: reset; synchronous, active-high.
- `i_valid` in 1: `i_data` carries an element.
- `i_data` in DATA_WIDTH: element value.
- `i_flush` in 1: discard the partial load and restart from element 0.
- `o_ready` out 1: loader accepts an element this cycle.
- `o_matrix_1` out FIRST_MATRIX_HEIGHT·BOTH_MATRIX_W_H·DATA_WIDTH: matrix 1, row-major, element (r,c) at bit offset `(r·BOTH_MATRIX_W_H+c)·DATA_WIDTH`.
- `o_matrix_2` out BOTH_MATRIX_W_H·SECOND_MATRIX_WIDTH·DATA_WIDTH: matrix 2, element (k,j) at bit offset `(k·SECOND_MATRIX_WIDTH+j)·DATA_WIDTH`.
- `o_calc` out 1: one-cycle start pulse to the multiplier.
- `o_done` out 1: one-cycle pulse on the last hold cycle.

## Operation
- Definitions:
  - N1 = FIRST_MATRIX_HEIGHT·BOTH_MATRIX_W_H.
  - N2 = BOTH_MATRIX_W_H·SECOND_MATRIX_WIDTH.
  - `idx` counter range 0..N1+N2−1, width `$clog2(N1+N2)`.
- FSM states and transitions:
  - LOAD: `o_ready`=1. An element is accepted when `i_valid` is high in a cycle with `o_ready` high.
    - While `idx`<N1, the accepted element is written into matrix 1 at `idx`.
    - Otherwise it is written into matrix 2 at position `idx`−N1, or the remapped position under the macro below.
    - After each acceptance, `idx`+1.
    - Acceptance at `idx`=N1+N2−1: go to FIRE and clear `idx` to 0.
  - FIRE: one cycle. `o_calc`=1, `o_ready`=0. Go to HOLD and load the hold counter with CALC_HOLD−1.
  - HOLD: `o_ready`=0. Decrement the hold counter. At count 0: `o_done`=1, go to LOAD.
- Flush:
  - `i_flush` in LOAD: `idx`←0.
  - Simultaneous `i_flush` and `i_valid`: flush wins and the element is dropped (not written, not counted).
  - `i_flush` in FIRE/HOLD is ignored.
- Operand registers:
  - Written only on accepted elements, and are not cleared between loads.
  - Matrix contents are stable through FIRE and HOLD.
  - Stale elements are visible during the next load until they are overwritten.
- Data is stored as-is. There is no arithmetic on elements and no sign handling.
- Reset (`i_rst` high at posedge):
  - state←LOAD, `idx`←0, hold counter←0, `o_matrix_1`/`o_matrix_2`←0, `o_calc`←0, `o_done`←0.
  - `o_ready` is forced 0 during any cycle with `i_rst` high.
  - Reset mid-load or mid-HOLD abandons the operation. No `o_calc`/`o_done` is produced for it.

## Timing
- `o_ready` is combinational from state and `i_rst` only. It never depends on `i_valid`.
- `o_calc` and `o_done` are registered.
- Last element accepted in cycle t:
  - Operands are complete from cycle t+1.
  - `o_calc`=1 in cycle t+1.
  - HOLD occupies cycles t+2 .. t+1+CALC_HOLD, with `o_done`=1 in cycle t+1+CALC_HOLD.
  - `o_ready`=1 again in cycle t+2+CALC_HOLD.
- Throughput: one element per cycle. Full pair cost is N1+N2+1+CALC_HOLD cycles.
- `o_calc` and `o_done` are never high in the same cycle and are never high for two consecutive cycles.

## Configuration
- Macro: `MATRIX_LOADER_COLMAJOR_EN`.
- Defined: matrix 2 elements arrive column-major. Stream index s=`idx`−N1 maps to k = s mod BOTH_MATRIX_W_H, j = s / BOTH_MATRIX_W_H, and is stored at `(k·SECOND_MATRIX_WIDTH+j)·DATA_WIDTH`.
- Undefined: matrix 2 arrives row-major and is stored at `s·DATA_WIDTH`.
- Matrix 1 is row-major in both cases. The output bus layout is identical in both cases.

## Test plan
All scenarios use FIRST_MATRIX_HEIGHT=BOTH_MATRIX_W_H=SECOND_MATRIX_WIDTH=2, DATA_WIDTH=8, CALC_HOLD=3 unless stated.
- Reset check: `i_rst` held 2 cycles, then released:
  - `o_ready` is 0 during reset and 1 after.
  - Both buses read 0.
  - `o_calc` and `o_done` are 0.
- Back-to-back stream 1..8, no macro:
  - `o_matrix_1`=0x04030201, `o_matrix_2`=0x08070605.
  - `o_calc` is 1 for exactly one cycle, the cycle after element 8.
  - `o_done` follows 3 cycles later.
  - `o_ready` returns the next cycle.
- Same stream with `MATRIX_LOADER_COLMAJOR_EN`: `o_matrix_2`=0x08060705 and `o_matrix_1` is unchanged.
- Flush:
  - Send 3 elements, then `i_flush` together with `i_valid` (data 0xAA), then 10..17.
  - Expected: 0xAA never stored, `o_matrix_1`=0x0D0C0B0A, `o_matrix_2`=0x11100F0E.
- `i_valid` held high through FIRE/HOLD with data 0xFF:
  - No element is accepted.
  - Both buses stay unchanged until `o_ready` returns.
  - The next accepted element lands at index 0.
- Reset asserted in the HOLD cycle preceding `o_done`: no `o_done` pulse, and state is LOAD with `idx`=0 after release.
